fir_hex_display: RTL and testbench

- Downstream consumer of the FIR filter output.
- Accepts one signed 16-bit filtered sample per valid/ready handshake.
- Converts the sample to sign plus five decimal digits using sequential double-dabble (shift-add-3).
- Drives six active-low seven-segment displays HEX5..HEX0 on the DE-series board, with a one-cycle pulse when a new value is shown.

---
 rtl/fir_pkg.sv | 23 ++
 rtl/seg7_decode.sv | 15 +
 rtl/fir_hex_display.sv | 132 +++++++++++++
 tb/tb_fir_hex_display.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR output display path.
package fir_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DIGITS = 5;
  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    LATCH = 2'd2
  } state_e;

  // Active-low segments ordered {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

endpackage

// File: rtl/seg7_decode.sv
// One BCD digit to active-low seven-segment pattern, with forced blanking.
module seg7_decode
  import fir_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    if (!blank && (digit <= 4'd9)) seg_c = SEG_DIGIT[digit];
  end

endmodule

// File: rtl/fir_hex_display.sv
// Signed sample to sign + five decimal digits on HEX5..HEX0 via sequential
// double-dabble; one display_valid pulse per displayed value.
module fir_hex_display
  import fir_pkg::*;
#(
  parameter int unsigned BLANK_LEADING = 1,
  parameter int unsigned DATA_W        = fir_pkg::DATA_W
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic [6:0]        HEX0,
  output logic [6:0]        HEX1,
  output logic [6:0]        HEX2,
  output logic [6:0]        HEX3,
  output logic [6:0]        HEX4,
  output logic [6:0]        HEX5,
  output logic              display_valid
);

  state_e             state_q, state_d;
  logic               neg_q, neg_d;
  logic               nz_q, nz_d;
  logic [DATA_W-1:0]  mag_q, mag_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [6:0]         hex_q [6];
  logic [6:0]         hex_d [6];
  logic               dv_q, dv_d;

  logic [BCD_W-1:0]   bcd_adj_c;
  logic [DIGITS-1:0]  blank_c;
  logic [6:0]         seg_c [DIGITS];

  assign sample_ready = (state_q == IDLE);

  // A digit blanks only when it and every more significant digit are zero.
  always_comb begin
    logic lead;
    lead    = (BLANK_LEADING != 0);
    blank_c = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lead       = lead && (bcd_q[4*i +: 4] == 4'd0);
      blank_c[i] = lead;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .digit (bcd_q[4*g +: 4]),
      .blank (blank_c[g]),
      .seg_c (seg_c[g])
    );
  end

  // Shift-add-3 correction applied before each shift.
  always_comb begin
    bcd_adj_c = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    neg_d   = neg_q;
    nz_d    = nz_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    hex_d   = hex_q;
    dv_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_valid) begin
          neg_d   = sample_in[DATA_W-1];
          nz_d    = (sample_in != '0);
          mag_d   = sample_in[DATA_W-1] ? DATA_W'(-sample_in) : sample_in;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        {bcd_d, mag_d} = {bcd_adj_c, mag_q} << 1;
        cnt_d          = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = LATCH;
      end
      LATCH: begin
        for (int i = 0; i < DIGITS; i++) hex_d[i] = seg_c[i];
        hex_d[5] = (neg_q && nz_q) ? SEG_MINUS : SEG_BLANK;
        dv_d     = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      neg_q   <= 1'b0;
      nz_q    <= 1'b0;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      dv_q    <= 1'b0;
      hex_q[0] <= SEG_DIGIT[0];
      for (int i = 1; i < 6; i++) hex_q[i] <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      neg_q   <= neg_d;
      nz_q    <= nz_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      dv_q    <= dv_d;
      for (int i = 0; i < 6; i++) hex_q[i] <= hex_d[i];
    end
  end

  assign HEX0          = hex_q[0];
  assign HEX1          = hex_q[1];
  assign HEX2          = hex_q[2];
  assign HEX3          = hex_q[3];
  assign HEX4          = hex_q[4];
  assign HEX5          = hex_q[5];
  assign display_valid = dv_q;

endmodule

// File: tb/tb_fir_hex_display.sv
// Randomized self-checking bench for fir_hex_display against a decimal model.
module tb_fir_hex_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        rdy_a, rdy_b, dv_a, dv_b;
  logic [6:0]  a0, a1, a2, a3, a4, a5;
  logic [6:0]  b0, b1, b2, b3, b4, b5;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int accepts = 0;
  int last_accept = 0;
  int prev_accept = 0;
  int dv_count = 0;

  localparam logic [41:0] RESET_HEX = {6{7'b1111111}} & ~42'h0 ^ 42'd0 ^ {35'h0, 7'b0111111};

  always #10 clk = ~clk;

  fir_hex_display #(.BLANK_LEADING(1)) dut_a (
    .CLOCK_50(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(rdy_a), .HEX0(a0), .HEX1(a1), .HEX2(a2), .HEX3(a3), .HEX4(a4), .HEX5(a5),
    .display_valid(dv_a));

  fir_hex_display #(.BLANK_LEADING(0)) dut_b (
    .CLOCK_50(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(rdy_b), .HEX0(b0), .HEX1(b1), .HEX2(b2), .HEX3(b3), .HEX4(b4), .HEX5(b5),
    .display_valid(dv_b));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst && sample_valid && rdy_a) begin
      accepts     <= accepts + 1;
      prev_accept <= last_accept;
      last_accept <= cyc;
    end
  end

  always @(negedge clk) if (dv_a) dv_count <= dv_count + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;  default: return 7'b1111111;
    endcase
  endfunction

  // Expected {HEX5..HEX0} computed from plain decimal arithmetic.
  function automatic logic [41:0] model(input int v, input bit blank);
    int m, d[5];
    bit lead;
    logic [41:0] r;
    m = (v < 0) ? -v : v;
    for (int i = 0; i < 5; i++) begin d[i] = m % 10; m = m / 10; end
    r[41:35] = (v < 0) ? 7'b0111111 : 7'b1111111;
    lead = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      if (d[i] != 0) lead = 1'b0;
      r[i*7 +: 7] = (blank && lead && i != 0) ? 7'b1111111 : seg_of(d[i]);
    end
    return r;
  endfunction

  function automatic logic [41:0] hex_a();
    return {a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic logic [41:0] hex_b();
    return {b5, b4, b3, b2, b1, b0};
  endfunction

  task automatic check_reset_outputs(input string tag);
    logic [41:0] exp;
    exp = {{5{7'b1111111}}, 7'b1000000};
    check_eq({tag, "_hex_a"}, 64'(hex_a()), 64'(exp));
    check_eq({tag, "_hex_b"}, 64'(hex_b()), 64'(exp));
    check_eq({tag, "_dv"}, 64'({dv_a, dv_b}), 64'd0);
    check_eq({tag, "_ready"}, 64'({rdy_a, rdy_b}), 64'd3);
  endtask

  // Counts edges from the accept edge to display_valid and checks the shown value.
  task automatic wait_display(input int v, input bit scramble);
    int lat;
    bit busy_ok;
    lat = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (dv_a) begin lat = k; break; end
      if (rdy_a || rdy_b) busy_ok = 1'b0;
      if (scramble) sample_in = 16'($urandom);
    end
    check_eq("latency", 64'(lat), 64'd17);
    check_eq("busy", 64'(busy_ok), 64'd1);
    check_eq("hex_blank", 64'(hex_a()), 64'(model(v, 1'b1)));
    check_eq("hex_full", 64'(hex_b()), 64'(model(v, 1'b0)));
    check_eq("dv_both", 64'(dv_b), 64'd1);
    @(posedge clk); #1;
    check_eq("dv_pulse", 64'(dv_a), 64'd0);
    check_eq("hex_hold", 64'(hex_a()), 64'(model(v, 1'b1)));
  endtask

  task automatic accept_and_check(input int v);
    int n;
    n = 0;
    while (!rdy_a && n < 50) begin @(posedge clk); #1; n++; end
    check_eq("ready_wait", 64'(rdy_a), 64'd1);
    sample_in    = 16'(v);
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    sample_in    = 16'($urandom);
    wait_display(v, 1'b1);
  endtask

  initial begin
    int dv_base, acc_base, v;
    int edge_vals[10] = '{14633, -81, -32768, 0, 32767, -1, 1, 10000, -10000, 100};
    rst = 1'b0;
    sample_in = '0;
    sample_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_low");
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("reset_rel");

    foreach (edge_vals[i]) accept_and_check(edge_vals[i]);

    // Back-to-back with valid held and sample_in changed mid-conversion.
    acc_base = accepts;
    sample_in = 16'(645);
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_in = 16'(318);
    wait_display(645, 1'b0);
    check_eq("b2b_ready_low", 64'(rdy_a), 64'd0);
    sample_valid = 1'b0;
    sample_in = 16'($urandom);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (dv_a) break;
      sample_in = 16'($urandom);
    end
    check_eq("b2b_second", 64'(hex_a()), 64'(model(318, 1'b1)));
    check_eq("b2b_accepts", 64'(accepts - acc_base), 64'd2);
    check_eq("b2b_spacing", 64'(last_accept - prev_accept), 64'd18);
    @(posedge clk); #1;

    // Reset mid-conversion.
    dv_base = dv_count;
    sample_in = 16'(4522);
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check_eq("abort_no_dv", 64'(dv_count - dv_base), 64'd0);
    check_eq("abort_hex", 64'(hex_a()), 64'({{5{7'b1111111}}, 7'b1000000}));
    accept_and_check(4522);

    for (int i = 0; i < 24; i++) begin
      v = int'($signed(16'($urandom)));
      accept_and_check(v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
